rib_sram_resp: RTL and testbench

- Word-addressed SRAM responder on the core-side RIB memory handshake: req / we / addr / wdata in, rdata / ready out.
- Sits on the far side of the data port driven by the core's execute stage (rib_ex_*), either directly or behind the bus arbiter.
- Inserts a programmable number of wait states and flags accesses outside its decoded window.
- Also usable as an instruction store when we_i is tied low.

---
 rtl/tinyriscv_pkg.sv | 17 +
 rtl/rib_sram_array.sv | 26 ++
 rtl/rib_sram_resp.sv | 115 +++++++++++
 tb/tb_rib_sram_resp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared core-side bus types for the tinyriscv memory path.
// Also carries the RIB responder state encoding, which the bus arbiter and monitors reuse.
package tinyriscv_pkg;

  localparam int MemBusW     = 32;
  localparam int MemAddrBusW = 32;

  typedef logic [MemBusW-1:0]     MemBus;
  typedef logic [MemAddrBusW-1:0] MemAddrBus;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_DONE = 2'd2
  } rib_resp_state_e;

endpackage

// File: rtl/rib_sram_array.sv
// Single-port synchronous RAM with a registered read port.
// Contents are not reset. A read during a write returns the old word.
module rib_sram_array #(
  parameter int DepthWords = 4096,
  parameter int DataW      = 32
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(DepthWords)-1:0] idx_i,
  input  logic [DataW-1:0]              wdata_i,
  output logic [DataW-1:0]              rdata_o
);

  logic [DataW-1:0] r_mem [DepthWords];
  logic [DataW-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[idx_i] <= wdata_i;
    end
    r_rdata <= r_mem[idx_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/rib_sram_resp.sv
// Word-addressed SRAM responder on the RIB memory handshake.
// It adds programmable wait states and flags accesses that fall outside its window.
//
// state     | meaning
// RESP_IDLE | no access in flight; a request is accepted at the end of this cycle
// RESP_WAIT | counting wait states down from WaitStates to 1
// RESP_DONE | ready_o cycle; a write hit commits at the closing edge
module rib_sram_resp
  import tinyriscv_pkg::*;
#(
  parameter int        DepthWords = 4096,
  parameter int        WaitStates = 1,
  parameter MemAddrBus BaseAddr   = 32'h1000_0000,
  parameter MemAddrBus AddrMask   = 32'hF000_0000
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      req_i,
  input  logic      we_i,
  input  MemAddrBus addr_i,
  input  MemBus     wdata_i,
  output MemBus     rdata_o,
  output logic      ready_o,
  output logic      err_o
);

  localparam int          IdxW    = $clog2(DepthWords);
  localparam logic [3:0]  WaitCnt = 4'(WaitStates);

  rib_resp_state_e r_state;
  rib_resp_state_e w_state_nxt;
  logic [3:0]      r_cnt;
  logic [IdxW-1:0] r_idx;
  logic            r_we;
  logic            r_hit;
  MemBus           r_wdata;

  logic            w_hit;
  logic [IdxW-1:0] w_idx;
  logic            w_cap;
  logic            w_done;
  logic            w_ram_we;
  logic [IdxW-1:0] w_ram_idx;
  MemBus           w_ram_rdata;

  assign w_hit = ((addr_i & AddrMask) == (BaseAddr & AddrMask));
  assign w_idx = addr_i[IdxW+1:2];

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    case (r_state)
      RESP_IDLE: begin
        if (req_i) begin
          w_cap       = 1'b1;
          w_state_nxt = (WaitStates > 0) ? RESP_WAIT : RESP_DONE;
        end
      end
      RESP_WAIT: begin
        if (!req_i) begin
          w_state_nxt = RESP_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = RESP_DONE;
        end
      end
      RESP_DONE: w_state_nxt = RESP_IDLE;
      default:   w_state_nxt = RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RESP_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap) begin
        r_idx   <= w_idx;
        r_we    <= we_i;
        r_hit   <= w_hit;
        r_wdata <= wdata_i;
        r_cnt   <= WaitCnt;
      end else if (w_state_nxt == RESP_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // With zero wait states the array must read at the accept edge, so IDLE addresses it from addr_i.
  assign w_ram_idx = (r_state == RESP_IDLE) ? w_idx : r_idx;
  assign w_done    = (r_state == RESP_DONE) && req_i;
  assign w_ram_we  = w_done && r_we && r_hit;

  rib_sram_array #(
    .DepthWords(DepthWords),
    .DataW     (MemBusW)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (w_ram_we),
    .idx_i  (w_ram_idx),
    .wdata_i(r_wdata),
    .rdata_o(w_ram_rdata)
  );

  assign ready_o = w_done;
  assign err_o   = w_done && !r_hit;
  assign rdata_o = (w_done && r_hit && !r_we) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_rib_sram_resp.sv
// Bench for rib_sram_resp: four instances with different wait-state settings.
// Directed and random accesses are checked against an array model of the word store.
module tb_rib_sram_resp;
  import tinyriscv_pkg::*;

  localparam int NI    = 4;
  localparam int Depth = 4096;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 0;
      default: return 2;
    endcase
  endfunction

  logic        clk;
  logic        rst_n [NI];
  logic        req   [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        ready [NI];
  logic        err   [NI];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl_mem [NI][Depth];
  bit          mdl_vld [NI][Depth];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rib_sram_resp #(
      .DepthWords(Depth),
      .WaitStates(ws_of(g))
    ) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n[g]),
      .req_i  (req[g]),
      .we_i   (we[g]),
      .addr_i (addr[g]),
      .wdata_i(wdata[g]),
      .rdata_o(rdata[g]),
      .ready_o(ready[g]),
      .err_o  (err[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit exp_hit(input logic [31:0] a);
    return (a >> 28) == 32'h1;
  endfunction

  function automatic int exp_idx(input logic [31:0] a);
    return int'((a >> 2) % Depth);
  endfunction

  // Entered just after a rising edge; leaves just after a rising edge with req dropped unless hold.
  task automatic do_access(input int k, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input bit hold, input bit scramble);
    int          ws;
    int          seen;
    int          ix;
    bit          h;
    bit          chk_rd;
    logic [31:0] exp_rd;
    ws     = ws_of(k);
    seen   = -1;
    h      = exp_hit(a);
    ix     = exp_idx(a);
    chk_rd = !w && (!h || mdl_vld[k][ix]);
    exp_rd = h ? mdl_mem[k][ix] : 32'h0;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    for (int cyc = 0; cyc < ws + 4 && seen < 0; cyc++) begin
      @(negedge clk);
      if (ready[k]) begin
        seen = cyc;
        check_val("err", 32'(err[k]), 32'(!h));
        if (chk_rd) check_val("rdata", rdata[k], exp_rd);
      end
      @(posedge clk); #1;
      if (cyc == 0 && scramble) begin
        addr[k]  = $urandom;
        wdata[k] = $urandom;
      end
      if (seen >= 0 && !hold) req[k] = 1'b0;
    end
    check_val("latency", 32'(seen), 32'(ws + 1));
    if (seen < 0) req[k] = 1'b0;
    if (seen >= 0 && w && h) begin
      mdl_mem[k][ix] = d;
      mdl_vld[k][ix] = 1'b1;
    end
  endtask

  // Drops req at the start of cycle ab_cyc (1..WaitStates+1); no completion may follow.
  task automatic do_abort(input int k, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input int ab_cyc);
    logic got;
    got    = 1'b0;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    for (int cyc = 0; cyc < ab_cyc + 4; cyc++) begin
      if (cyc == ab_cyc) req[k] = 1'b0;
      @(negedge clk);
      got = got | ready[k] | err[k];
      @(posedge clk); #1;
    end
    check_val("abort_no_ready", 32'(got), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 3) != 0) begin
      a = 32'h1000_0000 | ($urandom & 32'h0FFF_C000)
        | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    end else begin
      a = $urandom;
      if ((a >> 28) == 32'h1) a = a ^ 32'h6000_0000;
    end
    return a;
  endfunction

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      for (int i = 0; i < Depth; i++) mdl_vld[k][i] = 1'b0;
    end
    #1;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        check_val("rst_ready", 32'(ready[k]), 32'h0);
        check_val("rst_err", 32'(err[k]), 32'h0);
        check_val("rst_rdata", rdata[k], 32'h0);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        check_val("idle_ready", 32'(ready[k]), 32'h0);
        check_val("idle_rdata", rdata[k], 32'h0);
      end
    end
    @(posedge clk); #1;

    // Write/read and window miss, one wait state.
    do_access(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_access(0, 1'b0, 32'h1000_0010, 32'h0, 1'b0, 1'b0);
    do_access(0, 1'b1, 32'h1000_0000, 32'h0BAD_F00D, 1'b0, 1'b0);
    do_access(0, 1'b0, 32'h2000_0000, 32'h0, 1'b0, 1'b0);
    do_access(0, 1'b1, 32'h2000_0000, 32'h1234_5678, 1'b0, 1'b0);
    do_access(0, 1'b0, 32'h1000_0000, 32'h0, 1'b0, 1'b0);
    check_val("miss_kept_word", mdl_mem[0][0], 32'h0BAD_F00D);

    // Abort mid-wait, three wait states.
    do_access(1, 1'b1, 32'h1000_0020, 32'h1111_2222, 1'b0, 1'b0);
    do_abort(1, 1'b1, 32'h1000_0020, 32'hCAFE_F00D, 2);
    do_access(1, 1'b0, 32'h1000_0020, 32'h0, 1'b0, 1'b0);

    // Back-to-back reads with aliasing, zero wait states.
    do_access(2, 1'b1, 32'h1000_0000, 32'hA5A5_0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_access(2, 1'b0, 32'h1000_0000 + 32'(i) * 32'h4000, 32'h0, i < 3, 1'b0);
    end

    // Reset during the wait of a write, two wait states.
    do_access(3, 1'b1, 32'h1000_0040, 32'h5555_AAAA, 1'b0, 1'b0);
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h1000_0040; wdata[3] = 32'hFFFF_0000;
    @(negedge clk);
    check_val("rstmid_c0_ready", 32'(ready[3]), 32'h0);
    @(posedge clk); #1;
    rst_n[3] = 1'b0;
    @(negedge clk);
    check_val("rstmid_ready", 32'(ready[3]), 32'h0);
    req[3] = 1'b0;
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_val("rstmid_after", 32'(ready[3]), 32'h0);
    end
    @(posedge clk); #1;
    do_access(3, 1'b0, 32'h1000_0040, 32'h0, 1'b0, 1'b0);

    // Random traffic per instance.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 16; i++) begin
        do_access(k, 1'b1, 32'h1000_0000 | (32'(i) << 2), $urandom, 1'b0, 1'b0);
      end
      for (int n = 0; n < 80; n++) begin
        if ($urandom_range(0, 6) == 0) begin
          do_abort(k, 1'($urandom), rand_addr(), $urandom, $urandom_range(1, ws_of(k) + 1));
        end else begin
          do_access(k, 1'($urandom), rand_addr(), $urandom,
                    $urandom_range(0, 2) == 0, 1'($urandom));
        end
      end
      req[k] = 1'b0;
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
